// File: rtl/mining_fsm_if.sv
// mining_fsm_if: control/status bundle between the mining controller and the pipeline units.
interface mining_fsm_if;
  logic        start;
  logic        stopw;
  logic        fine;
  logic        fine_mining;
  logic [2:0]  state;
  logic [63:0] OUT;
  logic        reset_fsm;
  logic [31:0] NONCE;
  modport master (input start, stopw, fine, fine_mining, output state, OUT, reset_fsm, NONCE);
  modport slave (output start, stopw, fine, fine_mining, input state, OUT, reset_fsm, NONCE);
endinterface

// File: rtl/mining_fsm.sv
// mining_fsm: load/pad/hash sequencer retrying with incremented nonces; MINING_NONCE_LIMIT_EN stops at nonce 0xFFFFFFFF.
module mining_fsm #(
  parameter int          HASH_CYCLES = 200,
  parameter logic [31:0] NONCE_INIT  = '0
) (
  input logic          clock,
  input logic          reset,
  mining_fsm_if.master bus
);
  typedef enum logic [2:0] {IDLE = 3'b000, LOAD, PAD, HASH, RETRY, DONE, FAIL} state_t;
  state_t      st;
  logic [63:0] cnt;
  logic [63:0] cnt_inc;
  logic [31:0] hcnt;
  assign cnt_inc = &cnt ? cnt : cnt + 64'd1;
  assign bus.state = st;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      st            <= IDLE;
      cnt           <= '0;
      hcnt          <= '0;
      bus.OUT       <= '0;
      bus.NONCE     <= NONCE_INIT;
      bus.reset_fsm <= 1'b0;
    end else begin
      bus.reset_fsm <= 1'b0;
      case (st)
        IDLE: if (bus.start) begin
          st        <= LOAD;
          cnt       <= '0;
          bus.OUT   <= '0;
          bus.NONCE <= NONCE_INIT;
        end
        LOAD: begin
          cnt <= cnt_inc;
          if (bus.stopw) st <= PAD;
        end
        PAD: begin
          cnt  <= cnt_inc;
          hcnt <= '0;
          if (bus.fine) st <= HASH;
        end
        HASH: begin
          cnt  <= cnt_inc;
          hcnt <= hcnt + 32'd1;
          // success in the final allowed cycle still counts as a hit
          if (bus.fine_mining) begin
            st      <= DONE;
            bus.OUT <= cnt_inc;
          end else if (hcnt == 32'(HASH_CYCLES - 1)) begin
            st            <= RETRY;
            bus.reset_fsm <= 1'b1;
          end
        end
        RETRY: begin
          cnt <= cnt_inc;
`ifdef MINING_NONCE_LIMIT_EN
          if (&bus.NONCE) begin
            st      <= FAIL;
            bus.OUT <= '1;
          end else begin
            st        <= PAD;
            bus.NONCE <= bus.NONCE + 32'd1;
          end
`else
          st        <= PAD;
          bus.NONCE <= bus.NONCE + 32'd1;
`endif
        end
        DONE, FAIL: if (!bus.start) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mining_fsm.sv
// tb_mining_fsm: directed scoreboard bench; second instance starts at nonce 0xFFFFFFFF to exercise wrap/limit.
module tb_mining_fsm;
  logic clock = 1'b0;
  logic reset = 1'b0;
  mining_fsm_if a ();
  mining_fsm_if b ();
  mining_fsm dut (.clock(clock), .reset(reset), .bus(a.master));
  mining_fsm #(.HASH_CYCLES(200), .NONCE_INIT(32'hFFFF_FFFF)) dut2 (.clock(clock), .reset(reset), .bus(b.master));
  always #5 clock = ~clock;
  typedef struct {string tag; logic [63:0] val;} exp_t;
  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int retry_cnt = 0;
  int r0;
  always @(negedge clock) if (a.state == 3'd4) retry_cnt++;
  task automatic push_exp(input string tag, input logic [63:0] v);
    sb.push_back('{tag, v});
  endtask
  task automatic check_v(input logic [63:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
      return;
    end
    e = sb.pop_front();
    compared++;
    assert (obs === e.val) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
    end
  endtask
  task automatic step();
    @(negedge clock);
    cyc++;
  endtask
  initial begin
    {a.start, a.stopw, a.fine, a.fine_mining} = '0;
    {b.start, b.stopw, b.fine, b.fine_mining} = '0;
    repeat (3) @(negedge clock);
    push_exp("rst_state", 0);   check_v(64'(a.state));
    push_exp("rst_out", 0);     check_v(a.OUT);
    push_exp("rst_nonce", 0);   check_v(64'(a.NONCE));
    push_exp("rst_rfsm", 0);    check_v(64'(a.reset_fsm));
    reset = 1'b1;
    // run 1: timeout then success on 5th hash cycle of second nonce
    a.start = 1'b1;
    cyc = 0;
    push_exp("load", 1); step(); check_v(64'(a.state));
    repeat (31) step();
    push_exp("load_32", 1); check_v(64'(a.state));
    a.stopw = 1'b1;
    push_exp("pad", 2); step(); check_v(64'(a.state));
    a.stopw = 1'b0;
    step();
    a.fine = 1'b1;
    push_exp("hash", 3); step(); check_v(64'(a.state));
    a.fine = 1'b0;
    repeat (199) step();
    push_exp("hash_last", 3);    check_v(64'(a.state));
    push_exp("rfsm_in_hash", 0); check_v(64'(a.reset_fsm));
    push_exp("retry", 4); step(); check_v(64'(a.state));
    push_exp("rfsm_retry", 1); check_v(64'(a.reset_fsm));
    push_exp("repad", 2); step(); check_v(64'(a.state));
    push_exp("rfsm_cleared", 0); check_v(64'(a.reset_fsm));
    push_exp("nonce_inc", 1); check_v(64'(a.NONCE));
    a.fine = 1'b1;
    step();
    a.fine = 1'b0;
    repeat (4) step();
    a.fine_mining = 1'b1;
    push_exp("done", 5);
    push_exp("done_out", 64'(cyc));
    push_exp("done_nonce", 1);
    step(); check_v(64'(a.state)); check_v(a.OUT); check_v(64'(a.NONCE));
    a.fine_mining = 1'b0;
    push_exp("retries_run1", 1); check_v(64'(retry_cnt));
    push_exp("done_hold", 5); step(); check_v(64'(a.state));
    a.start = 1'b0;
    push_exp("idle", 0); step(); check_v(64'(a.state));
    // run 2: success coincident with timeout cycle
    r0 = retry_cnt;
    a.start = 1'b1;
    cyc = 0;
    step();
    a.stopw = 1'b1;
    step();
    a.stopw = 1'b0;
    a.fine = 1'b1;
    step();
    a.fine = 1'b0;
    repeat (199) step();
    a.fine_mining = 1'b1;
    push_exp("tie_done", 5);
    push_exp("tie_out", 64'(cyc));
    push_exp("tie_nonce", 0);
    step(); check_v(64'(a.state)); check_v(a.OUT); check_v(64'(a.NONCE));
    a.fine_mining = 1'b0;
    push_exp("tie_no_retry", 64'(r0)); check_v(64'(retry_cnt));
    a.start = 1'b0;
    step();
    // run 3: nonce 0xFFFFFFFF timeout
    b.start = 1'b1;
    step();
    b.stopw = 1'b1;
    step();
    b.stopw = 1'b0;
    b.fine = 1'b1;
    step();
    b.fine = 1'b0;
    repeat (199) step();
    push_exp("max_retry", 4); step(); check_v(64'(b.state));
    push_exp("max_rfsm", 1); check_v(64'(b.reset_fsm));
    push_exp("max_nonce", 64'hFFFF_FFFF); check_v(64'(b.NONCE));
`ifdef MINING_NONCE_LIMIT_EN
    push_exp("limit_fail", 6); step(); check_v(64'(b.state));
    push_exp("limit_out", 64'hFFFF_FFFF_FFFF_FFFF); check_v(b.OUT);
    b.start = 1'b0;
    push_exp("fail_exit", 0); step(); check_v(64'(b.state));
`else
    push_exp("wrap_pad", 2); step(); check_v(64'(b.state));
    push_exp("wrap_nonce", 0); check_v(64'(b.NONCE));
`endif
    // run 4: asynchronous abort mid-run
    a.start = 1'b1;
    step();
    step();
    #2 reset = 1'b0;
    #1;
    push_exp("abort_state", 0); check_v(64'(a.state));
    push_exp("abort_out", 0);   check_v(a.OUT);
    push_exp("abort_nonce", 0); check_v(64'(a.NONCE));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
